// File: rtl/hc595_chain_driver.sv
// hc595_chain_driver
//   Serial controller for a daisy chain of N_CHIPS 74HC595 shift/latch chips.
//   A parallel word is accepted through start (or a chain clear through clr)
//   while idle, shifted out on ds/shcp with CLK_DIV clk cycles per half-period,
//   then latched with one stcp pulse; done pulses for one cycle at the end.
//
//   Ports
//     clk      system clock, rising edge
//     rst      synchronous reset, active-high
//     start    transfer request (idle only), data_in captured on that cycle
//     clr      chain clear request (idle only), wins over start
//     enable   1 drives the 595 outputs (oe_n low)
//     data_in  word to shift, 8*N_CHIPS bits
//     busy     transfer/clear in progress
//     done     one-cycle completion pulse
//     ds, shcp, stcp, mr_n, oe_n   595 pins, all registered
module hc595_chain_driver #(
  parameter int N_CHIPS   = 1,
  parameter int CLK_DIV   = 2,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   clr,
  input  logic                   enable,
  input  logic [8*N_CHIPS-1:0]   data_in,
  output logic                   busy,
  output logic                   done,
  output logic                   ds,
  output logic                   shcp,
  output logic                   stcp,
  output logic                   mr_n,
  output logic                   oe_n
);

  localparam int W     = 8 * N_CHIPS;
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BIT_W = $clog2(W + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_SHIFT_HI,
    S_CLEAR,
    S_LATCH,
    S_DONE
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic [DIV_W-1:0] div_cnt;
  logic [BIT_W-1:0] bit_cnt;
  logic [W-1:0]     shreg;
  logic [W-1:0]     shreg_shifted;
  logic             tick;
  logic             accept_xfer;

  // Bit that goes out next on ds for a given shift-register image.
  function automatic logic first_bit(input logic [W-1:0] v);
    return MSB_FIRST ? v[W-1] : v[0];
  endfunction

  // Shift-register image after the current bit has been clocked out.
  function automatic logic [W-1:0] shift_out(input logic [W-1:0] v);
    return MSB_FIRST ? {v[W-2:0], 1'b0} : {1'b0, v[W-1:1]};
  endfunction

  assign tick          = (div_cnt == DIV_LAST);
  assign shreg_shifted = shift_out(shreg);
  assign accept_xfer   = (state == S_IDLE) && !clr && start;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: begin
        if (clr) begin
          state_nx = S_CLEAR;
        end else if (start) begin
          state_nx = S_SETUP;
        end
      end
      S_SETUP:    if (tick) state_nx = S_SHIFT_HI;
      S_SHIFT_HI: if (tick) state_nx = (bit_cnt == BIT_W'(1)) ? S_LATCH : S_SETUP;
      S_CLEAR:    if (tick) state_nx = S_LATCH;
      S_LATCH:    if (tick) state_nx = S_DONE;
      S_DONE:     state_nx = S_IDLE;
      default:    state_nx = S_IDLE;
    endcase
  end

  // Control and pin registers: every pin is set on the edge that enters the
  // state it belongs to, so pins line up with the state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt <= '0;
      bit_cnt <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      ds      <= 1'b0;
      shcp    <= 1'b0;
      stcp    <= 1'b0;
      mr_n    <= 1'b0;
      oe_n    <= 1'b1;
    end else begin
      oe_n    <= ~enable;
      div_cnt <= ((state == S_IDLE) || tick) ? '0 : div_cnt + 1'b1;
      done    <= 1'b0;
      mr_n    <= 1'b1;
      case (state)
        S_IDLE: begin
          if (clr) begin
            busy <= 1'b1;
            mr_n <= 1'b0;
            ds   <= 1'b0;
          end else if (start) begin
            busy    <= 1'b1;
            bit_cnt <= BIT_W'(W);
            ds      <= first_bit(data_in);
          end
        end
        S_SETUP: begin
          if (tick) shcp <= 1'b1;
        end
        S_SHIFT_HI: begin
          if (tick) begin
            shcp    <= 1'b0;
            bit_cnt <= bit_cnt - 1'b1;
            if (bit_cnt == BIT_W'(1)) begin
              stcp <= 1'b1;
              ds   <= 1'b0;
            end else begin
              // ds moves only together with the falling shcp edge.
              ds <= first_bit(shreg_shifted);
            end
          end
        end
        S_CLEAR: begin
          // Hold MR low for the whole CLEAR window, then latch the zeros.
          if (tick) begin
            stcp <= 1'b1;
          end else begin
            mr_n <= 1'b0;
          end
        end
        S_LATCH: begin
          if (tick) stcp <= 1'b0;
        end
        S_DONE: begin
          done <= 1'b1;
          busy <= 1'b0;
        end
        default: begin
          busy <= 1'b0;
        end
      endcase
    end
  end

  // Data path: no reset, only loaded on accept and advanced per shifted bit.
  always_ff @(posedge clk) begin
    if (accept_xfer) begin
      shreg <= data_in;
    end else if ((state == S_SHIFT_HI) && tick) begin
      shreg <= shreg_shifted;
    end
  end

endmodule

// File: tb/tb_hc595_chain_driver.sv
// Bench for hc595_chain_driver: two instances share the control inputs,
//   instance 0: one chip, MSB first; instance 1: two chips, LSB first.
//   A schedule model predicts every pin per cycle from the accept cycle, and
//   a 595 chain model driven by the DUT pins gives the latched contents.
module tb_hc595_chain_driver;

  localparam int D = 2;

  logic        clk    = 1'b0;
  logic        rst    = 1'b1;
  logic        start  = 1'b0;
  logic        clr    = 1'b0;
  logic        enable = 1'b0;
  logic [7:0]  data_a = 8'h00;
  logic [15:0] data_b = 16'h0000;

  logic [1:0] busy_v, done_v, ds_v, shcp_v, stcp_v, mr_v, oe_v;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  hc595_chain_driver #(.N_CHIPS(1), .CLK_DIV(D), .MSB_FIRST(1'b1)) u_dut_a (
    .clk(clk), .rst(rst), .start(start), .clr(clr), .enable(enable),
    .data_in(data_a),
    .busy(busy_v[0]), .done(done_v[0]), .ds(ds_v[0]), .shcp(shcp_v[0]),
    .stcp(stcp_v[0]), .mr_n(mr_v[0]), .oe_n(oe_v[0])
  );

  hc595_chain_driver #(.N_CHIPS(2), .CLK_DIV(D), .MSB_FIRST(1'b0)) u_dut_b (
    .clk(clk), .rst(rst), .start(start), .clr(clr), .enable(enable),
    .data_in(data_b),
    .busy(busy_v[1]), .done(done_v[1]), .ds(ds_v[1]), .shcp(shcp_v[1]),
    .stcp(stcp_v[1]), .mr_n(mr_v[1]), .oe_n(oe_v[1])
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- schedule model ----------------
  int          cyc = 0;
  bit          act_m  [2];
  bit          clr_m  [2];
  int          t0     [2];
  logic [15:0] word_m [2];
  bit          rst_seen  = 1'b1;
  bit          exp_oe_n  = 1'b1;

  function automatic int wbits(input int i);
    return (i == 0) ? 8 : 16;
  endfunction

  function automatic int end_k(input int i);
    return clr_m[i] ? (2 * D + 1) : (2 * wbits(i) * D + D + 1);
  endfunction

  // Expected {busy, done, ds, shcp, stcp, mr_n} after the current edge.
  function automatic logic [5:0] exp_out(input int i);
    int   k, w, bi;
    logic bitv, high;
    w = wbits(i);
    if (rst_seen) return 6'b000000;
    if (!act_m[i]) return 6'b000001;
    k = cyc - t0[i];
    if (k > end_k(i)) return 6'b000001;
    if (k == end_k(i)) return 6'b010001;
    if (clr_m[i]) begin
      if (k < D) return 6'b100000;
      if (k < 2 * D) return 6'b100011;
      return 6'b100001;
    end
    if (k < 2 * w * D) begin
      bi   = k / (2 * D);
      high = ((k % (2 * D)) >= D);
      bitv = (i == 0) ? word_m[i][w - 1 - bi] : word_m[i][bi];
      return {1'b1, 1'b0, bitv, high, 1'b0, 1'b1};
    end
    if (k < 2 * w * D + D) return 6'b100011;
    return 6'b100001;
  endfunction

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      rst_seen = 1'b1;
      exp_oe_n = 1'b1;
      for (int i = 0; i < 2; i++) act_m[i] = 1'b0;
    end else begin
      rst_seen = 1'b0;
      exp_oe_n = ~enable;
      for (int i = 0; i < 2; i++) begin
        if ((!act_m[i] || (cyc - t0[i]) > end_k(i)) && (clr || start)) begin
          act_m[i]  = 1'b1;
          clr_m[i]  = clr;
          t0[i]     = cyc;
          word_m[i] = (i == 0) ? {8'h00, data_a} : data_b;
        end
      end
    end
  end

  // ---------------- compare + 595 chain model ----------------
  logic [15:0] sr [2];
  logic [15:0] q  [2];
  logic [15:0] ds_log [2];
  logic [1:0]  shcp_prev = 2'b00;
  logic [1:0]  stcp_prev = 2'b00;
  logic [1:0]  first_ds;
  int rises    [2];
  int stcp_cnt [2];
  int mr_low   [2];
  int done_cnt [2];
  int lat      [2];

  initial begin
    for (int i = 0; i < 2; i++) begin
      sr[i] = '0; q[i] = '0; ds_log[i] = '0;
      rises[i] = 0; stcp_cnt[i] = 0; mr_low[i] = 0; done_cnt[i] = 0; lat[i] = 0;
    end
    first_ds = 2'b00;
  end

  always @(posedge clk) begin
    logic [5:0] e;
    logic [15:0] mask;
    #1;
    for (int i = 0; i < 2; i++) begin
      e = exp_out(i);
      chk($sformatf("busy[%0d] cyc %0d", i, cyc), busy_v[i], e[5]);
      chk($sformatf("done[%0d] cyc %0d", i, cyc), done_v[i], e[4]);
      chk($sformatf("ds[%0d] cyc %0d", i, cyc),   ds_v[i],   e[3]);
      chk($sformatf("shcp[%0d] cyc %0d", i, cyc), shcp_v[i], e[2]);
      chk($sformatf("stcp[%0d] cyc %0d", i, cyc), stcp_v[i], e[1]);
      chk($sformatf("mr_n[%0d] cyc %0d", i, cyc), mr_v[i],   e[0]);
      chk($sformatf("oe_n[%0d] cyc %0d", i, cyc), oe_v[i],   exp_oe_n);

      mask = (i == 0) ? 16'h00FF : 16'hFFFF;
      if (!mr_v[i]) begin
        sr[i] = '0;
        mr_low[i]++;
      end else if (shcp_v[i] && !shcp_prev[i]) begin
        if (rises[i] == 0) first_ds[i] = ds_v[i];
        sr[i]     = ((sr[i] << 1) | {15'd0, ds_v[i]}) & mask;
        ds_log[i] = (ds_log[i] << 1) | {15'd0, ds_v[i]};
        rises[i]++;
      end
      if (stcp_v[i] && !stcp_prev[i]) begin
        q[i] = sr[i];
        stcp_cnt[i]++;
      end
      if (done_v[i]) begin
        done_cnt[i]++;
        lat[i] = cyc - t0[i];
      end
      shcp_prev[i] = shcp_v[i];
      stcp_prev[i] = stcp_v[i];
    end
  end

  // LSB-first chains are read back with Q7..Q0 reversed, so the logical word
  // is the bit-reverse of the physical 16-bit storage image.
  function automatic logic [15:0] rev16(input logic [15:0] v);
    logic [15:0] r;
    for (int j = 0; j < 16; j++) r[j] = v[15 - j];
    return r;
  endfunction

  task automatic clear_stats();
    for (int i = 0; i < 2; i++) begin
      rises[i] = 0; stcp_cnt[i] = 0; mr_low[i] = 0; ds_log[i] = '0;
    end
    first_ds = 2'b00;
  endtask

  task automatic wait_done(input int i, input int target, input int budget);
    int n;
    n = 0;
    while (done_cnt[i] < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("done_seen[%0d]", i), 32'(done_cnt[i] >= target), 32'd1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int dc0, dc1;
    // reset
    repeat (3) @(negedge clk);
    chk("rst mr_n", mr_v[0], 1'b0);
    chk("rst oe_n", oe_v[0], 1'b1);
    chk("rst busy", busy_v[0], 1'b0);
    chk("rst shcp|stcp|ds", {shcp_v[0], stcp_v[0], ds_v[0]}, 3'b000);
    rst = 1'b0;
    @(negedge clk);
    chk("mr_n after release", mr_v[0], 1'b1);

    // A5 on the single chip, 1234 LSB-first on the pair
    enable = 1'b1;
    clear_stats();
    dc0 = done_cnt[0]; dc1 = done_cnt[1];
    data_a = 8'hA5; data_b = 16'h1234; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(0, dc0 + 1, 100);
    chk("a latency", lat[0], 35);
    chk("a shcp rises", rises[0], 8);
    chk("a ds sequence", ds_log[0][7:0], 8'hA5);
    chk("a stcp pulses", stcp_cnt[0], 1);
    chk("a out_q", q[0][7:0], 8'hA5);
    wait_done(1, dc1 + 1, 100);
    chk("b latency", lat[1], 67);
    chk("b shcp rises", rises[1], 16);
    chk("b first ds", first_ds[1], 1'b0);
    chk("b chip0", rev16(q[1])[7:0], 8'h34);
    chk("b chip1", rev16(q[1])[15:8], 8'h12);

    // clr and start together: clear wins
    repeat (2) @(negedge clk);
    clear_stats();
    dc0 = done_cnt[0]; dc1 = done_cnt[1];
    data_a = 8'hFF; data_b = 16'hFFFF; clr = 1'b1; start = 1'b1;
    @(negedge clk);
    clr = 1'b0; start = 1'b0;
    wait_done(0, dc0 + 1, 20);
    chk("clr latency", lat[0], 5);
    chk("clr mr_n low cycles", mr_low[0], 2);
    chk("clr stcp pulses", stcp_cnt[0], 1);
    chk("clr shcp rises", rises[0], 0);
    chk("clr a out_q", q[0], 16'h0000);
    wait_done(1, dc1 + 1, 20);
    chk("clr b out_q", q[1], 16'h0000);

    // start held high: ignored while busy, re-accepted right after done
    repeat (2) @(negedge clk);
    dc0 = done_cnt[0]; dc1 = done_cnt[1];
    data_a = 8'h3C; data_b = 16'hC3A5; start = 1'b1;
    @(negedge clk);
    data_a = 8'h11; data_b = 16'hFFFF;
    wait_done(0, dc0 + 1, 100);
    data_a = 8'h5A;
    chk("b2b first word", q[0][7:0], 8'h3C);
    @(negedge clk);
    start = 1'b0;
    wait_done(1, dc1 + 1, 100);
    chk("b word unaffected by data change", rev16(q[1]), 16'hC3A5);
    wait_done(0, dc0 + 2, 100);
    chk("b2b second word", q[0][7:0], 8'h5A);
    chk("b2b second latency", lat[0], 35);
    chk("b no restart", done_cnt[1], dc1 + 1);

    // enable toggles during a transfer
    repeat (2) @(negedge clk);
    dc0 = done_cnt[0]; dc1 = done_cnt[1];
    enable = 1'b0; data_a = 8'h81; data_b = 16'h8001; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    enable = 1'b1;
    repeat (10) @(negedge clk);
    enable = 1'b0;
    wait_done(0, dc0 + 1, 100);
    chk("enable latency", lat[0], 35);
    chk("enable out_q", q[0][7:0], 8'h81);
    wait_done(1, dc1 + 1, 100);
    chk("enable b word", rev16(q[1]), 16'h8001);
    enable = 1'b1;

    // extra start mid-transfer, then reset at the third shcp rise
    repeat (2) @(negedge clk);
    clear_stats();
    dc0 = done_cnt[0]; dc1 = done_cnt[1];
    data_a = 8'hFF; data_b = 16'hFFFF; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int n = 0; n < 50 && rises[0] < 3; n++) @(negedge clk);
    chk("third shcp rise reached", rises[0], 3);
    rst = 1'b1;
    @(negedge clk);
    chk("abort busy", busy_v[0], 1'b0);
    chk("abort shcp|ds|mr_n", {shcp_v[0], ds_v[0], mr_v[0]}, 3'b000);
    @(negedge clk);
    rst = 1'b0;
    repeat (80) @(negedge clk);
    chk("no done after abort a", done_cnt[0], dc0);
    chk("no done after abort b", done_cnt[1], dc1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
